data_ram_lsu: RTL and testbench

//  Parametrised data RAM with a built-in load/store unit for the RV32 core's data bus. Provides byte/half/word stores via

---
 rtl/data_ram_lsu.sv | 214 +++++++++++++++++++++
 tb/tb_data_ram_lsu.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_lsu
// Purpose  : Word-organised data RAM with a load/store unit: byte-lane merged
//            stores, sign/zero-extended loads, registered read port, and
//            automatic two-beat splitting of word-crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_lsu #(
    parameter int ADDR_W      = 8,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        BHW,
    input  logic              lu,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int WW    = ADDR_W - 2;
    localparam int DEPTH = 2 ** WW;

    localparam logic [1:0] SL_BYTE = 2'b00;
    localparam logic [1:0] SL_HALF = 2'b01;
    localparam logic [1:0] SL_WORD = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            rvalid_q, rvalid_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            we_q, we_d;
    logic            lu_q, lu_d;
    logic [1:0]      bhw_q, bhw_d;
    logic [1:0]      off_q, off_d;
    logic [WW-1:0]   w2_q, w2_d;
    logic [3:0]      hi_mask_q, hi_mask_d;
    logic [31:0]     hi_data_q, hi_data_d;
    logic [31:0]     lo_word_q, lo_word_d;

    logic [31:0]     mem [DEPTH];

    logic [WW-1:0]   word_idx;
    logic [1:0]      off;
    logic [3:0]      size_mask;
    logic [7:0]      lane8;
    logic [63:0]     data64;
    logic            reserved;
    logic            misaligned;
    logic            reject;
    logic            accept;
    logic [WW-1:0]   rd_idx;
    logic [31:0]     rd_word;
    logic            wr_en;
    logic [WW-1:0]   wr_idx;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_data;

    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [1:0]  sz,
                                           input logic        uns);
        logic [31:0] r;
        case (sz)
            SL_BYTE: r = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            SL_HALF: r = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        word_idx = addr[ADDR_W-1:2];
        off      = addr[1:0];
        case (BHW)
            SL_BYTE: size_mask = 4'b0001;
            SL_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        reserved   = (BHW == 2'b11);
        misaligned = ((BHW == SL_HALF) && (off == 2'd3)) ||
                     ((BHW == SL_WORD) && (off != 2'd0));
        reject     = reserved || (misaligned && !MISALIGN_EN);
        accept     = cs && ready_q;
        // Lanes/data spread over two words; the upper half belongs to word w+1.
        lane8      = {4'b0000, size_mask} << off;
        data64     = {32'h0, wdata} << {off, 3'b000};
        rd_idx     = (state_q == S_SPLIT) ? w2_q : word_idx;
        rd_word    = mem[rd_idx];
        if (state_q == S_SPLIT) begin
            wr_en   = we_q;
            wr_idx  = w2_q;
            wr_mask = hi_mask_q;
            wr_data = hi_data_q;
        end else begin
            wr_en   = accept && we && !reject;
            wr_idx  = word_idx;
            wr_mask = lane8[3:0];
            wr_data = data64[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        we_d      = we_q;
        lu_d      = lu_q;
        bhw_d     = bhw_q;
        off_d     = off_q;
        w2_d      = w2_q;
        hi_mask_d = hi_mask_q;
        hi_data_d = hi_data_q;
        lo_word_d = lo_word_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = 32'h0;
                    end else if (misaligned) begin
                        state_d   = S_SPLIT;
                        we_d      = we;
                        lu_d      = lu;
                        bhw_d     = BHW;
                        off_d     = off;
                        w2_d      = word_idx + WW'(1);
                        hi_mask_d = lane8[7:4];
                        hi_data_d = data64[63:32];
                        lo_word_d = rd_word;
                    end else begin
                        rvalid_d = 1'b1;
                        if (!we) begin
                            rdata_d = extend(rd_word >> {off, 3'b000}, BHW, lu);
                        end
                    end
                end
            end
            S_SPLIT: begin
                state_d  = S_IDLE;
                rvalid_d = 1'b1;
                if (!we_q) begin
                    rdata_d = extend(32'({rd_word, lo_word_q} >> {off_q, 3'b000}),
                                     bhw_q, lu_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            we_q      <= 1'b0;
            lu_q      <= 1'b0;
            bhw_q     <= 2'b00;
            off_q     <= 2'b00;
            w2_q      <= '0;
            hi_mask_q <= 4'h0;
            hi_data_q <= 32'h0;
            lo_word_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            lu_q      <= lu_d;
            bhw_q     <= bhw_d;
            off_q     <= off_d;
            w2_q      <= w2_d;
            hi_mask_q <= hi_mask_d;
            hi_data_q <= hi_data_d;
            lo_word_q <= lo_word_d;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_lsu
// Purpose  : Self-checking bench: byte-array reference model, directed and
//            randomized load/store traffic on two LSU instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_a, cs_b, we, lu;
    logic [7:0]  addr;
    logic [1:0]  bhw;
    logic [31:0] wdata;
    logic        ready_a, rvalid_a, err_a;
    logic        ready_b, rvalid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [256];

    always #5 clk = ~clk;

    data_ram_lsu #(.ADDR_W(8), .MISALIGN_EN(1'b1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .cs(cs_a), .we(we), .addr(addr), .BHW(bhw),
        .lu(lu), .wdata(wdata), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a)
    );

    data_ram_lsu #(.ADDR_W(8), .MISALIGN_EN(1'b0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .cs(cs_b), .we(we), .addr(addr), .BHW(bhw),
        .lu(lu), .wdata(wdata), .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b)
    );

    // ---------------- reference model (byte addressed, little-endian) -------
    function automatic int sz(input logic [1:0] b);
        return (b == 2'd0) ? 1 : (b == 2'd1) ? 2 : (b == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit crosses(input logic [7:0] a, input logic [1:0] b);
        return (int'(a[1:0]) + sz(b) - 1) > 3;
    endfunction

    function automatic bit m_bad(input logic [7:0] a, input logic [1:0] b, input bit en);
        return (b == 2'd3) || (!en && crosses(a, b));
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] a, input logic [1:0] b, input logic u);
        logic [31:0] v = 32'h0;
        int n = sz(b);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[(int'(a) + i) % 256];
        if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void m_store(input logic [7:0] a, input logic [1:0] b, input logic [31:0] d);
        for (int i = 0; i < sz(b); i++) mm[(int'(a) + i) % 256] = d[8*i +: 8];
    endfunction

    // ---------------- bus driver: one request, waits (bounded) for rvalid ----
    task automatic op(input bit d, input logic w, input logic [7:0] a, input logic [1:0] b,
                      input logic l, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat, output logic rdy1);
        @(negedge clk);
        we = w; addr = a; bhw = b; lu = l; wdata = wd;
        if (d) cs_b = 1'b1; else cs_a = 1'b1;
        @(negedge clk);
        cs_a = 1'b0; cs_b = 1'b0;
        rdy1 = d ? ready_b : ready_a;
        lat = 99; rd = 32'hDEAD_0000; e = 1'bx;
        for (int i = 1; i <= 4; i++) begin
            if (d ? rvalid_b : rvalid_a) begin
                lat = i; rd = d ? rdata_b : rdata_a; e = d ? err_b : err_a;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (ready_a !== 1'b1 || rvalid_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_a phase%0d: got rdy=%b rv=%b err=%b rd=%h expected 1 0 0 0",
                         p, ready_a, rvalid_a, err_a, rdata_a);
            end
            checks++;
            if (ready_b !== 1'b1 || rvalid_b !== 1'b0 || err_b !== 1'b0 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_b phase%0d: got rdy=%b rv=%b err=%b rd=%h expected 1 0 0 0",
                         p, ready_b, rvalid_b, err_b, rdata_b);
            end
            reset_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic init_mem();
        logic [31:0] rd; logic e, r1; int lat;
        for (int i = 0; i < 64; i++) op(0, 1'b1, 8'(i * 4), 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        for (int i = 0; i < 256; i++) mm[i] = 8'h0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e, r1; int lat;
        op(0, 1'b1, 8'h10, 2'd2, 1'b0, 32'hAABB_CCDD, rd, e, lat, r1);
        m_store(8'h10, 2'd2, 32'hAABB_CCDD);
        checks++;
        if (lat !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL word_store: got lat=%0d err=%b expected lat=1 err=0", lat, e);
        end
        op(0, 1'b0, 8'h10, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (lat !== 1 || rd !== 32'hAABB_CCDD) begin
            errors++; $display("FAIL word_load: got lat=%0d rd=%h expected lat=1 rd=aabbccdd", lat, rd);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic e, r1; int lat;
        logic [31:0] exp_v [4] = '{32'h0000_007F, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7F00};
        logic [7:0]  la [4]    = '{8'h11, 8'h12, 8'h12, 8'h10};
        logic [1:0]  lb [4]    = '{2'd0, 2'd1, 2'd1, 2'd2};
        logic        ll [4]    = '{1'b0, 1'b0, 1'b1, 1'b0};
        op(0, 1'b1, 8'h10, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        op(0, 1'b1, 8'h11, 2'd0, 1'b0, 32'h0000_007F, rd, e, lat, r1);
        op(0, 1'b1, 8'h12, 2'd1, 1'b0, 32'h0000_8001, rd, e, lat, r1);
        m_store(8'h10, 2'd2, 32'h0);
        m_store(8'h11, 2'd0, 32'h7F);
        m_store(8'h12, 2'd1, 32'h8001);
        for (int i = 0; i < 4; i++) begin
            op(0, 1'b0, la[i], lb[i], ll[i], 32'h0, rd, e, lat, r1);
            checks++;
            if (lat !== 1 || rd !== exp_v[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL subword_load%0d: got lat=%0d rd=%h err=%b expected lat=1 rd=%h err=0",
                         i, lat, rd, e, exp_v[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic e, r1; int lat;
        op(0, 1'b1, 8'h05, 2'd2, 1'b0, 32'h1122_3344, rd, e, lat, r1);
        m_store(8'h05, 2'd2, 32'h1122_3344);
        checks++;
        if (r1 !== 1'b0 || lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL mis_store: got ready1=%b lat=%0d err=%b expected 0 2 0", r1, lat, e);
        end
        op(0, 1'b0, 8'h04, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h2233_4400) begin
            errors++; $display("FAIL mis_word04: got %h expected 22334400", rd);
        end
        op(0, 1'b0, 8'h08, 2'd0, 1'b1, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h0000_0011) begin
            errors++; $display("FAIL mis_byte08: got %h expected 00000011", rd);
        end
        op(0, 1'b0, 8'h05, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h1122_3344 || lat !== 2 || r1 !== 1'b0) begin
            errors++;
            $display("FAIL mis_load: got rd=%h lat=%0d ready1=%b expected 11223344 2 0", rd, lat, r1);
        end
        op(0, 1'b0, 8'h07, 2'd1, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== m_load(8'h07, 2'd1, 1'b0) || lat !== 2) begin
            errors++;
            $display("FAIL mis_half07: got rd=%h lat=%0d expected %h 2", rd, lat, m_load(8'h07, 2'd1, 1'b0));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e, r1; int lat;
        op(0, 1'b1, 8'hFE, 2'd2, 1'b0, 32'hCAFE_BABE, rd, e, lat, r1);
        m_store(8'hFE, 2'd2, 32'hCAFE_BABE);
        op(0, 1'b0, 8'hFC, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'hBABE_0000) begin
            errors++; $display("FAIL wrap_w63: got %h expected babe0000", rd);
        end
        op(0, 1'b0, 8'h00, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h0000_CAFE) begin
            errors++; $display("FAIL wrap_w0: got %h expected 0000cafe", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e, r1; int lat;
        op(1, 1'b1, 8'h00, 2'd2, 1'b0, 32'h1234_5678, rd, e, lat, r1);
        op(1, 1'b1, 8'h01, 2'd2, 1'b0, 32'hFFFF_FFFF, rd, e, lat, r1);
        checks++;
        if (e !== 1'b1 || lat !== 1 || rd !== 32'h0 || r1 !== 1'b1) begin
            errors++;
            $display("FAIL err_mis_word: got err=%b lat=%0d rd=%h ready1=%b expected 1 1 0 1", e, lat, rd, r1);
        end
        op(1, 1'b1, 8'h03, 2'd1, 1'b0, 32'h0000_FFFF, rd, e, lat, r1);
        checks++;
        if (e !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL err_mis_half: got err=%b lat=%0d expected 1 1", e, lat);
        end
        op(1, 1'b0, 8'h00, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin
            errors++; $display("FAIL err_unchanged: got rd=%h err=%b expected 12345678 0", rd, e);
        end
        op(1, 1'b0, 8'h02, 2'd1, 1'b1, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== 32'h0000_1234 || e !== 1'b0) begin
            errors++; $display("FAIL err_b_half: got rd=%h err=%b expected 00001234 0", rd, e);
        end
        op(0, 1'b1, 8'h10, 2'd3, 1'b0, 32'hFFFF_FFFF, rd, e, lat, r1);
        checks++;
        if (e !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
            errors++; $display("FAIL err_reserved: got err=%b lat=%0d rd=%h expected 1 1 0", e, lat, rd);
        end
        op(0, 1'b0, 8'h10, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== m_load(8'h10, 2'd2, 1'b0)) begin
            errors++; $display("FAIL err_res_unchanged: got %h expected %h", rd, m_load(8'h10, 2'd2, 1'b0));
        end
    endtask

    task automatic test_reset_split();
        logic [31:0] rd; logic e, r1; int lat;
        @(negedge clk);
        we = 1'b1; addr = 8'h21; bhw = 2'd2; lu = 1'b0; wdata = 32'hDEAD_BEEF; cs_a = 1'b1;
        @(negedge clk);
        cs_a = 1'b0;
        checks++;
        if (ready_a !== 1'b0) begin
            errors++; $display("FAIL rst_split_enter: got ready=%b expected 0", ready_a);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready_a !== 1'b1 || rvalid_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL rst_split_out: got rdy=%b rv=%b err=%b rd=%h expected 1 0 0 0",
                     ready_a, rvalid_a, err_a, rdata_a);
        end
        for (int i = 1; i < 4; i++) mm[8'h20 + i] = wdata[8*(i-1) +: 8];
        @(negedge clk);
        reset_n = 1'b1;
        op(0, 1'b0, 8'h20, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== m_load(8'h20, 2'd2, 1'b0) || lat !== 1) begin
            errors++;
            $display("FAIL rst_split_w0: got rd=%h lat=%0d expected %h 1", rd, lat, m_load(8'h20, 2'd2, 1'b0));
        end
        op(0, 1'b0, 8'h24, 2'd2, 1'b0, 32'h0, rd, e, lat, r1);
        checks++;
        if (rd !== m_load(8'h24, 2'd2, 1'b0) || lat !== 1) begin
            errors++;
            $display("FAIL rst_split_w1: got rd=%h lat=%0d expected %h 1", rd, lat, m_load(8'h24, 2'd2, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_d; logic e, r1, w, l, bad, cr; int lat, r;
        logic [7:0] a; logic [1:0] b;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            b = (r == 9) ? 2'd3 : 2'(r % 3);
            a = 8'($urandom); w = 1'($urandom); l = 1'($urandom); wd = $urandom;
            bad   = m_bad(a, b, 1'b1);
            cr    = !bad && crosses(a, b);
            exp_d = bad ? 32'h0 : m_load(a, b, l);
            op(0, w, a, b, l, wd, rd, e, lat, r1);
            if (!bad && w) m_store(a, b, wd);
            checks++;
            if (lat !== (cr ? 2 : 1) || e !== bad || r1 !== !cr) begin
                errors++;
                $display("FAIL rand%0d_ctl a=%h b=%0d we=%b: got lat=%0d err=%b rdy1=%b expected %0d %b %b",
                         n, a, b, w, lat, e, r1, cr ? 2 : 1, bad, !cr);
            end
            if (!w || bad) begin
                checks++;
                if (rd !== exp_d) begin
                    errors++;
                    $display("FAIL rand%0d_data a=%h b=%0d lu=%b: got %h expected %h", n, a, b, l, rd, exp_d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pa, pw, act, w, l; logic [31:0] pe, wd; logic [7:0] a; logic [1:0] b;
        pa = 1'b0; pw = 1'b0; pe = 32'h0;
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (rvalid_a !== pa || ready_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b%0d_valid: got rv=%b rdy=%b expected %b 1", k, rvalid_a, ready_a, pa);
                end
                if (pa && !pw) begin
                    checks++;
                    if (rdata_a !== pe) begin
                        errors++; $display("FAIL b2b%0d_data: got %h expected %h", k, rdata_a, pe);
                    end
                end
            end
            act = ($urandom_range(0, 3) != 0) && (k < 80);
            b = 2'($urandom_range(0, 2));
            a = 8'($urandom);
            if (b == 2'd1 && a[1:0] == 2'd3) a[0] = 1'b0;
            if (b == 2'd2) a[1:0] = 2'd0;
            w = 1'($urandom); l = 1'($urandom); wd = $urandom;
            we = w; addr = a; bhw = b; lu = l; wdata = wd; cs_a = act;
            if (act && w) m_store(a, b, wd);
            if (act && !w) pe = m_load(a, b, l);
            pa = act; pw = w;
        end
        cs_a = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cs_a = 1'b0; cs_b = 1'b0; we = 1'b0; lu = 1'b0;
        addr = 8'h0; bhw = 2'd0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        init_mem();
        test_word();
        test_subword();
        test_misaligned();
        test_wrap();
        test_errors();
        test_reset_split();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
